// File: rtl/conv_pkg.sv
// Shared defaults and fixed-point helpers (round-half-up shift, saturation) for the conv accumulators.
package conv_pkg;

  localparam int CONV_WD      = 16;
  localparam int CONV_WD_BIAS = 32;
  localparam int CONV_SHIFT   = 15;

  // Helpers work on a 64-bit signed intermediate wide enough for acc + bias + rounding term.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int sh);
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int wd);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wd - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wd - 1));
    return (x > hi) || (x < lo);
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int wd);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wd - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wd - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_acc_lane.sv
// One output lane: multiply (P1), reduce (P2), accumulate (P3), bias/round/saturate (P4).
// Optional ReLU after saturation when CONV_ACC_RELU_EN is defined.
module conv_acc_lane
  import conv_pkg::*;
#(
  parameter int INPUT_NUM = 6,
  parameter int WD        = CONV_WD,
  parameter int WD_BIAS   = CONV_WD_BIAS,
  parameter int ACC_W     = 40,
  parameter int SHIFT     = CONV_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_en,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [WD*INPUT_NUM-1:0]     image,
  input  logic [WD*INPUT_NUM-1:0]     weight,
  input  logic [WD_BIAS-1:0]          bias,
  output logic [WD-1:0]               q,
  output logic                        q_en,
  output logic                        sat_pulse
);

  logic signed [2*WD-1:0]    prod [INPUT_NUM];
  logic                      v1, f1, l1, v2, f2, l2, v3;
  logic signed [WD_BIAS-1:0] b1, b2, b3;
  logic signed [ACC_W-1:0]   sum_c, sum, acc;
  logic signed [63:0]        total_c, shr_c;
  logic signed [WD-1:0]      res_c;
  logic                      clamp_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < INPUT_NUM; i++) sum_c = sum_c + ACC_W'(prod[i]);
  end

  always_comb begin
    total_c = 64'(acc) + 64'(b3);
    shr_c   = round_shift(total_c, SHIFT);
    clamp_c = sat_hit(shr_c, WD);
    res_c   = WD'(sat_val(shr_c, WD));
`ifdef CONV_ACC_RELU_EN
    if (res_c < 0) res_c = '0;
`endif
    sat_pulse = v3 & clamp_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUT_NUM; i++) prod[i] <= '0;
      {v1, f1, l1, v2, f2, l2, v3} <= '0;
      b1   <= '0;
      b2   <= '0;
      b3   <= '0;
      sum  <= '0;
      acc  <= '0;
      q    <= '0;
      q_en <= 1'b0;
    end else begin
      v1 <= in_en;
      if (in_en) begin
        for (int i = 0; i < INPUT_NUM; i++)
          prod[i] <= $signed(image[i*WD +: WD]) * $signed(weight[i*WD +: WD]);
        f1 <= in_first;
        l1 <= in_last;
        b1 <= $signed(bias);
      end
      v2 <= v1;
      if (v1) begin
        sum <= sum_c;
        f2  <= f1;
        l2  <= l1;
        b2  <= b1;
      end
      // Only a last beat needs P4; bubbles leave acc untouched.
      v3 <= v2 & l2;
      if (v2) begin
        acc <= f2 ? sum : acc + sum;
        b3  <= b2;
      end
      q_en <= v3;
      if (v3) q <= res_c;
    end
  end

endmodule

// File: rtl/conv_acc_multi.sv
// Multi-input, multi-output conv accumulator: OUTPUT_NUM lockstep lanes plus a sticky overflow flag.
// Build option: CONV_ACC_RELU_EN clamps negative results to zero.
module conv_acc_multi
  import conv_pkg::*;
#(
  parameter int INPUT_NUM  = 6,
  parameter int OUTPUT_NUM = 16,
  parameter int WD         = CONV_WD,
  parameter int WD_BIAS    = CONV_WD_BIAS,
  parameter int ACC_W      = 40,
  parameter int SHIFT      = CONV_SHIFT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_en,
  input  logic                               in_first,
  input  logic                               in_last,
  input  logic [WD*INPUT_NUM-1:0]            image,
  input  logic [WD*INPUT_NUM*OUTPUT_NUM-1:0] weight,
  input  logic [WD_BIAS*OUTPUT_NUM-1:0]      bias,
  output logic [WD*OUTPUT_NUM-1:0]           q,
  output logic                               q_en,
  output logic                               ovf
);

  logic [OUTPUT_NUM-1:0] q_en_lane;
  logic [OUTPUT_NUM-1:0] sat_lane;

  for (genvar o = 0; o < OUTPUT_NUM; o++) begin : g_lane
    conv_acc_lane #(
      .INPUT_NUM (INPUT_NUM),
      .WD        (WD),
      .WD_BIAS   (WD_BIAS),
      .ACC_W     (ACC_W),
      .SHIFT     (SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_en     (in_en),
      .in_first  (in_first),
      .in_last   (in_last),
      .image     (image),
      .weight    (weight[o*WD*INPUT_NUM +: WD*INPUT_NUM]),
      .bias      (bias[o*WD_BIAS +: WD_BIAS]),
      .q         (q[o*WD +: WD]),
      .q_en      (q_en_lane[o]),
      .sat_pulse (sat_lane[o])
    );
  end

  // Lanes run in lockstep, so lane 0's strobe speaks for all of them.
  assign q_en = q_en_lane[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf <= 1'b0;
    else if (|sat_lane) ovf <= 1'b1;
  end

endmodule
